// File: rtl/mem_cmd_pkg.sv
// mem_cmd_pkg: shared state type, register map and bit positions for mem_cmd_csr
package mem_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_TEST
    } state_t;

    localparam logic [7:0] OFF_ADDR   = 8'h00;
    localparam logic [7:0] OFF_WDATA  = 8'h08;
    localparam logic [7:0] OFF_BURST  = 8'h10;
    localparam logic [7:0] OFF_CMD    = 8'h18;
    localparam logic [7:0] OFF_STATUS = 8'h20;
    localparam logic [7:0] OFF_RDATA  = 8'h28;
    localparam logic [7:0] OFF_LAT    = 8'h30;

    localparam int ST_BUSY       = 0;
    localparam int ST_WR_DONE    = 1;
    localparam int ST_RD_DONE    = 2;
    localparam int ST_TEST_DONE  = 3;
    localparam int ST_TIMEOUT    = 4;
    localparam int ST_BUSY_ERR   = 5;
    localparam int ST_RDWR_STAT  = 8;
    localparam int ST_ADDR_STAT  = 16;

    localparam int CMD_WR   = 0;
    localparam int CMD_RD   = 1;
    localparam int CMD_TEST = 2;
    localparam int CMD_CLR  = 3;

    function automatic logic [11:0] burst_fix(input logic [11:0] b);
        return (b == 12'd0) ? 12'd1 : b;
    endfunction

endpackage

// File: rtl/mem_cmd_timer.sv
// mem_cmd_timer: saturating per-command latency counter with timeout compare
module mem_cmd_timer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             pClk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] lat,
    output logic             expired
);

    always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n)
            lat <= '0;
        else if (clr)
            lat <= '0;
        else if (en && lat != '1)
            lat <= lat + 1'b1;
    end

    assign expired = lat >= CNT_W'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/mem_cmd_csr.sv
// mem_cmd_csr: host CSR window and command sequencer driving the mem_fsm control inputs
module mem_cmd_csr
    import mem_cmd_pkg::*;
#(
    parameter int                 MMIO_AW        = 16,
    parameter logic [MMIO_AW-1:0] CSR_BASE       = 16'h0040,
    parameter int                 TIMEOUT_CYCLES = 4096,
    parameter int                 CNT_W          = 32
) (
    input  logic               pClk,
    input  logic               pck_cp2af_softReset_n,
    input  logic               mmio_wr_valid,
    input  logic [MMIO_AW-1:0] mmio_wr_addr,
    input  logic [63:0]        mmio_wr_data,
    input  logic               mmio_rd_valid,
    input  logic [MMIO_AW-1:0] mmio_rd_addr,
    input  logic [8:0]         mmio_rd_tid,
    output logic               mmio_rd_rsp_valid,
    output logic [63:0]        mmio_rd_rsp_data,
    output logic [8:0]         mmio_rd_rsp_tid,
    output logic [31:0]        avm_address,
    output logic [63:0]        avm_writedata,
    output logic [11:0]        avm_burstcount,
    output logic               avm_write,
    output logic               avm_read,
    output logic               mem_testmode,
    output logic               rdwr_reset,
    input  logic [63:0]        avm_readdata,
    input  logic               addr_test_done,
    input  logic [4:0]         addr_test_status,
    input  logic [1:0]         rdwr_done,
    input  logic [4:0]         rdwr_status
);

    state_t             state, state_nx;
    logic               busy, op_rd, rd_cap;
    logic               wr_done, rd_done, test_done, timeout, busy_err;
    logic [31:0]        addr_sh, addr_lv;
    logic [63:0]        wdata_sh, wdata_lv, rdata, status, rd_mux;
    logic [11:0]        burst_sh, burst_lv;
    logic [MMIO_AW-1:0] wr_off, rd_off;
    logic [2:0]         go;
    logic               cmd_wr, multi, start_rw, start_test, err_set, clr_sticky;
    logic               done_hit, test_hit, to_hit, lat_clr, lat_en, expired;
    logic [CNT_W-1:0]   lat;

    assign wr_off     = mmio_wr_addr - CSR_BASE;
    assign rd_off     = mmio_rd_addr - CSR_BASE;
    assign go         = mmio_wr_data[2:0];
    assign busy       = state != S_IDLE;
    assign cmd_wr     = mmio_wr_valid && wr_off == MMIO_AW'(OFF_CMD);
    assign multi      = (go[0] & go[1]) | (go[0] & go[2]) | (go[1] & go[2]);
    assign start_rw   = cmd_wr && !busy && !multi && (go[CMD_WR] || go[CMD_RD]);
    assign start_test = cmd_wr && !busy && !go[CMD_WR] && !go[CMD_RD] && go[CMD_TEST];
    assign err_set    = cmd_wr && go != 3'd0 && (busy || multi);
    // A clear bundled with a go bit while busy is rejected as a whole
    assign clr_sticky = cmd_wr && mmio_wr_data[CMD_CLR] && !(busy && go != 3'd0);
    assign done_hit   = state == S_WAIT && (op_rd ? rdwr_done[1] : rdwr_done[0]);
    assign test_hit   = state == S_TEST && addr_test_done;
    assign to_hit     = (state == S_WAIT || state == S_TEST) && expired && !done_hit && !test_hit;
    assign lat_clr    = state == S_ISSUE || start_test;
    assign lat_en     = state == S_WAIT || state == S_TEST;

    mem_cmd_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .pClk    (pClk),
        .rst_n   (pck_cp2af_softReset_n),
        .clr     (lat_clr),
        .en      (lat_en),
        .lat     (lat),
        .expired (expired)
    );

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        rdwr_reset   = state == S_CLEAR;
        avm_write    = state == S_ISSUE && !op_rd;
        avm_read     = state == S_ISSUE && op_rd;
        mem_testmode = state == S_TEST;
        unique case (state)
            S_IDLE:  state_nx = start_rw ? S_CLEAR : start_test ? S_TEST : S_IDLE;
            S_CLEAR: state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  state_nx = (done_hit || to_hit) ? S_IDLE : S_WAIT;
            S_TEST:  state_nx = (test_hit || to_hit) ? S_IDLE : S_TEST;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            op_rd     <= 1'b0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            test_done <= 1'b0;
            timeout   <= 1'b0;
            busy_err  <= 1'b0;
            rd_cap    <= 1'b0;
            rdata     <= '0;
        end else begin
            if (start_rw)
                op_rd <= go[CMD_RD];
            wr_done   <= (start_rw || start_test) ? 1'b0 : wr_done | (done_hit && !op_rd);
            rd_done   <= (start_rw || start_test) ? 1'b0 : rd_done | (done_hit && op_rd);
            test_done <= (start_rw || start_test) ? 1'b0 : test_done | test_hit;
            timeout   <= to_hit ? 1'b1 : clr_sticky ? 1'b0 : timeout;
            busy_err  <= err_set ? 1'b1 : clr_sticky ? 1'b0 : busy_err;
            // mem_fsm presents read data one cycle after its done flag
            rd_cap    <= done_hit && op_rd;
            if (rd_cap)
                rdata <= avm_readdata;
        end
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            addr_sh  <= '0;
            wdata_sh <= '0;
            burst_sh <= 12'd1;
            addr_lv  <= '0;
            wdata_lv <= '0;
            burst_lv <= 12'd1;
        end else begin
            if (mmio_wr_valid && wr_off == MMIO_AW'(OFF_ADDR))
                addr_sh <= mmio_wr_data[31:0];
            if (mmio_wr_valid && wr_off == MMIO_AW'(OFF_WDATA))
                wdata_sh <= mmio_wr_data;
            if (mmio_wr_valid && wr_off == MMIO_AW'(OFF_BURST))
                burst_sh <= burst_fix(mmio_wr_data[11:0]);
            if (state == S_CLEAR) begin
                addr_lv  <= addr_sh;
                wdata_lv <= wdata_sh;
                burst_lv <= burst_sh;
            end
        end
    end

    assign avm_address    = addr_lv;
    assign avm_writedata  = wdata_lv;
    assign avm_burstcount = burst_lv;

    always_comb begin
        status                            = '0;
        status[ST_BUSY]                   = busy;
        status[ST_WR_DONE]                = wr_done;
        status[ST_RD_DONE]                = rd_done;
        status[ST_TEST_DONE]              = test_done;
        status[ST_TIMEOUT]                = timeout;
        status[ST_BUSY_ERR]               = busy_err;
        status[ST_RDWR_STAT +: 5]         = rdwr_status;
        status[ST_ADDR_STAT +: 5]         = addr_test_status;
    end

    assign rd_mux = rd_off == MMIO_AW'(OFF_ADDR)   ? {32'd0, addr_sh} :
                    rd_off == MMIO_AW'(OFF_WDATA)  ? wdata_sh :
                    rd_off == MMIO_AW'(OFF_BURST)  ? {52'd0, burst_sh} :
                    rd_off == MMIO_AW'(OFF_STATUS) ? status :
                    rd_off == MMIO_AW'(OFF_RDATA)  ? rdata :
                    rd_off == MMIO_AW'(OFF_LAT)    ? 64'(lat) : '0;

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            mmio_rd_rsp_valid <= 1'b0;
            mmio_rd_rsp_data  <= '0;
            mmio_rd_rsp_tid   <= '0;
        end else begin
            mmio_rd_rsp_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                mmio_rd_rsp_data <= rd_mux;
                mmio_rd_rsp_tid  <= mmio_rd_tid;
            end
        end
    end

endmodule

// File: tb/tb_mem_cmd_csr.sv
// tb_mem_cmd_csr: directed vector bench for mem_cmd_csr with a hand-driven mem_fsm stand-in
module tb_mem_cmd_csr;

    localparam int TO = 128;
    localparam logic [15:0] A_ADDR   = 16'h40;
    localparam logic [15:0] A_WDATA  = 16'h48;
    localparam logic [15:0] A_BURST  = 16'h50;
    localparam logic [15:0] A_CMD    = 16'h58;
    localparam logic [15:0] A_STATUS = 16'h60;
    localparam logic [15:0] A_RDATA  = 16'h68;
    localparam logic [15:0] A_LAT    = 16'h70;
    localparam logic [15:0] A_UNMAP  = 16'h78;

    logic        pClk = 1'b0;
    logic        rst_n;
    logic        mmio_wr_valid, mmio_rd_valid;
    logic [15:0] mmio_wr_addr, mmio_rd_addr;
    logic [63:0] mmio_wr_data;
    logic [8:0]  mmio_rd_tid;
    logic        mmio_rd_rsp_valid;
    logic [63:0] mmio_rd_rsp_data;
    logic [8:0]  mmio_rd_rsp_tid;
    logic [31:0] avm_address;
    logic [63:0] avm_writedata;
    logic [11:0] avm_burstcount;
    logic        avm_write, avm_read, mem_testmode, rdwr_reset;
    logic [63:0] avm_readdata;
    logic        addr_test_done;
    logic [4:0]  addr_test_status, rdwr_status;
    logic [1:0]  rdwr_done;

    mem_cmd_csr #(.TIMEOUT_CYCLES(TO)) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rst_n),
        .mmio_wr_valid         (mmio_wr_valid),
        .mmio_wr_addr          (mmio_wr_addr),
        .mmio_wr_data          (mmio_wr_data),
        .mmio_rd_valid         (mmio_rd_valid),
        .mmio_rd_addr          (mmio_rd_addr),
        .mmio_rd_tid           (mmio_rd_tid),
        .mmio_rd_rsp_valid     (mmio_rd_rsp_valid),
        .mmio_rd_rsp_data      (mmio_rd_rsp_data),
        .mmio_rd_rsp_tid       (mmio_rd_rsp_tid),
        .avm_address           (avm_address),
        .avm_writedata         (avm_writedata),
        .avm_burstcount        (avm_burstcount),
        .avm_write             (avm_write),
        .avm_read              (avm_read),
        .mem_testmode          (mem_testmode),
        .rdwr_reset            (rdwr_reset),
        .avm_readdata          (avm_readdata),
        .addr_test_done        (addr_test_done),
        .addr_test_status      (addr_test_status),
        .rdwr_done             (rdwr_done),
        .rdwr_status           (rdwr_status)
    );

    always #5 pClk = ~pClk;

    int n_chk = 0;
    int n_err = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int clr_pulses = 0;
    logic [8:0] tid_ctr = 9'h010;

    // Strobe counters sample mid-high phase so the main flow sees them by the next negedge
    always @(posedge pClk) begin
        #2;
        if (avm_write) wr_pulses++;
        if (avm_read) rd_pulses++;
        if (rdwr_reset) clr_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mw(input logic [15:0] a, input logic [63:0] d);
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = a;
        mmio_wr_data  = d;
        @(negedge pClk);
        mmio_wr_valid = 1'b0;
    endtask

    task automatic rchk(input string name, input logic [15:0] a, input logic [63:0] exp);
        logic [8:0] t;
        t = tid_ctr;
        tid_ctr = tid_ctr + 9'd7;
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = a;
        mmio_rd_tid   = t;
        @(negedge pClk);
        mmio_rd_valid = 1'b0;
        chk({name, "_vld"}, {63'd0, mmio_rd_rsp_valid}, 64'd1);
        chk({name, "_tid"}, {55'd0, mmio_rd_rsp_tid}, {55'd0, t});
        chk(name, mmio_rd_rsp_data, exp);
    endtask

    typedef struct {
        logic [15:0] wa;
        logic [63:0] wd;
        logic [15:0] ra;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int wp0, rp0, cp0, cnt;
        rst_n = 1'b0;
        mmio_wr_valid = 0; mmio_wr_addr = '0; mmio_wr_data = '0;
        mmio_rd_valid = 0; mmio_rd_addr = '0; mmio_rd_tid = '0;
        avm_readdata = '0; addr_test_done = 0; addr_test_status = '0;
        rdwr_done = '0; rdwr_status = '0;

        vecs[0]  = '{A_ADDR,   64'hFFFF_FFFF_1234_5678, A_ADDR,   64'h1234_5678,           "addr_w32"};
        vecs[1]  = '{A_WDATA,  64'hA5A5_0000_1234_5678, A_WDATA,  64'hA5A5_0000_1234_5678, "wdata_rw"};
        vecs[2]  = '{A_BURST,  64'h0,                   A_BURST,  64'h1,                   "burst_zero"};
        vecs[3]  = '{A_BURST,  64'hFFFF,                A_BURST,  64'hFFF,                 "burst_w12"};
        vecs[4]  = '{A_STATUS, 64'hFF,                  A_STATUS, 64'h0,                   "status_ro"};
        vecs[5]  = '{A_RDATA,  64'h1234,                A_RDATA,  64'h0,                   "rdata_ro"};
        vecs[6]  = '{A_LAT,    64'h55,                  A_LAT,    64'h0,                   "lat_ro"};
        vecs[7]  = '{A_UNMAP,  64'h77,                  A_UNMAP,  64'h0,                   "unmap_rd"};
        vecs[8]  = '{16'h0038, 64'h1,                   A_ADDR,   64'h1234_5678,           "below_base"};
        vecs[9]  = '{A_ADDR,   64'h10,                  A_ADDR,   64'h10,                  "addr_set"};
        vecs[10] = '{16'h0044, 64'hFF,                  A_ADDR,   64'h10,                  "misaligned"};
        vecs[11] = '{A_WDATA,  64'hDEAD_BEEF,           A_WDATA,  64'hDEAD_BEEF,           "wdata_set"};
        vecs[12] = '{A_BURST,  64'h1,                   A_BURST,  64'h1,                   "burst_set"};
        vecs[13] = '{A_ADDR,   64'h10,                  A_CMD,    64'h0,                   "cmd_wo"};

        repeat (3) @(negedge pClk);
        chk("rst_rsp_valid", {63'd0, mmio_rd_rsp_valid}, 64'd0);
        chk("rst_address", {32'd0, avm_address}, 64'd0);
        chk("rst_wdata", avm_writedata, 64'd0);
        chk("rst_burst", {52'd0, avm_burstcount}, 64'd1);
        chk("rst_strobes", {60'd0, avm_write, avm_read, mem_testmode, rdwr_reset}, 64'd0);
        rst_n = 1'b1;
        @(negedge pClk);
        rchk("rst_status", A_STATUS, 64'h0);
        rchk("rst_lat", A_LAT, 64'h0);
        rchk("rst_burst_reg", A_BURST, 64'h1);

        for (int i = 0; i < 14; i++) begin
            mw(vecs[i].wa, vecs[i].wd);
            rchk(vecs[i].name, vecs[i].ra, vecs[i].exp);
        end
        chk("shadow_only_addr", {32'd0, avm_address}, 64'd0);
        chk("shadow_only_burst", {52'd0, avm_burstcount}, 64'd1);

        // Write command: done 5 cycles after the avm_write pulse
        wp0 = wr_pulses; cp0 = clr_pulses;
        rdwr_status = 5'h0A;
        mw(A_CMD, 64'h1);
        chk("wr_clear_pulse", {63'd0, rdwr_reset}, 64'd1);
        @(negedge pClk);
        chk("wr_issue", {62'd0, avm_write, rdwr_reset}, 64'b10);
        chk("wr_address", {32'd0, avm_address}, 64'h10);
        chk("wr_wdata", avm_writedata, 64'hDEAD_BEEF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge pClk);
            if (i == 5) rdwr_done = 2'b01;
        end
        @(negedge pClk);
        rdwr_done = 2'b00;
        chk("wr_pulse_count", 64'(wr_pulses - wp0), 64'd1);
        chk("wr_clr_count", 64'(clr_pulses - cp0), 64'd1);
        rchk("wr_status", A_STATUS, 64'hA02);
        rchk("wr_lat", A_LAT, 64'd5);
        rdwr_status = 5'h0;

        // Read command: done 3 cycles after avm_read, data captured a cycle later
        rp0 = rd_pulses;
        mw(A_CMD, 64'h2);
        @(negedge pClk);
        chk("rd_issue", {62'd0, avm_read, avm_write}, 64'b10);
        for (int i = 1; i <= 3; i++) begin
            @(negedge pClk);
            if (i == 3) begin
                avm_readdata = 64'hCAFE;
                rdwr_done = 2'b10;
            end
        end
        @(negedge pClk);
        rdwr_done = 2'b00;
        rchk("rd_status", A_STATUS, 64'h4);
        rchk("rd_rdata", A_RDATA, 64'hCAFE);
        rchk("rd_lat", A_LAT, 64'd3);
        chk("rd_pulse_count", 64'(rd_pulses - rp0), 64'd1);

        // Address test: done raised on the 70th testmode cycle
        addr_test_status = 5'h15;
        mw(A_CMD, 64'h4);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!mem_testmode) break;
            cnt++;
            if (cnt == 70) addr_test_done = 1'b1;
            @(negedge pClk);
        end
        addr_test_done = 1'b0;
        chk("test_mode_cycles", 64'(cnt), 64'd70);
        rchk("test_status", A_STATUS, 64'h15_0008);
        addr_test_status = 5'h0;

        // Timeout: no done from the model
        mw(A_CMD, 64'h1);
        @(negedge pClk);
        repeat (120) @(negedge pClk);
        rchk("to_still_busy", A_STATUS, 64'h1);
        repeat (10) @(negedge pClk);
        rchk("to_status", A_STATUS, 64'h10);
        rchk("to_lat", A_LAT, 64'(TO));
        mw(A_CMD, 64'h8);
        rchk("to_cleared", A_STATUS, 64'h0);

        // Busy rejection and shadow registers
        mw(A_BURST, 64'h7);
        wp0 = wr_pulses;
        mw(A_CMD, 64'h1);
        @(negedge pClk);
        chk("bz_burst_live", {52'd0, avm_burstcount}, 64'd7);
        chk("bz_addr_live", {32'd0, avm_address}, 64'h10);
        mw(A_ADDR, 64'h99);
        mw(A_CMD, 64'h1);
        chk("bz_addr_stable", {32'd0, avm_address}, 64'h10);
        rchk("bz_err_status", A_STATUS, 64'h21);
        rdwr_done = 2'b01;
        @(negedge pClk);
        rdwr_done = 2'b00;
        rchk("bz_done_status", A_STATUS, 64'h22);
        chk("bz_single_pulse", 64'(wr_pulses - wp0), 64'd1);
        rchk("bz_addr_shadow", A_ADDR, 64'h99);
        chk("bz_addr_idle", {32'd0, avm_address}, 64'h10);
        mw(A_CMD, 64'h8);
        rchk("bz_err_cleared", A_STATUS, 64'h2);
        mw(A_CMD, 64'h3);
        chk("multi_ignored", {63'd0, rdwr_reset}, 64'd0);
        rchk("multi_status", A_STATUS, 64'h22);
        mw(A_CMD, 64'h9);
        chk("clr_go_start", {63'd0, rdwr_reset}, 64'd1);
        @(negedge pClk);
        chk("addr_reload", {32'd0, avm_address}, 64'h99);
        mw(A_CMD, 64'h2);
        rchk("busy_rd_err", A_STATUS, 64'h21);
        mw(A_CMD, 64'h8);
        rchk("clr_while_busy", A_STATUS, 64'h01);
        rdwr_done = 2'b01;
        @(negedge pClk);
        rdwr_done = 2'b00;
        rchk("bz_final", A_STATUS, 64'h2);

        // Unmapped read with a specific tid
        mmio_rd_valid = 1'b1; mmio_rd_addr = A_UNMAP; mmio_rd_tid = 9'h1A5;
        @(negedge pClk);
        mmio_rd_valid = 1'b0;
        chk("unmap_vld", {63'd0, mmio_rd_rsp_valid}, 64'd1);
        chk("unmap_data", mmio_rd_rsp_data, 64'd0);
        chk("unmap_tid", {55'd0, mmio_rd_rsp_tid}, 64'h1A5);
        @(negedge pClk);
        chk("rsp_one_cycle", {63'd0, mmio_rd_rsp_valid}, 64'd0);

        // Same-cycle read and write of ADDR
        mmio_wr_valid = 1'b1; mmio_wr_addr = A_ADDR; mmio_wr_data = 64'h55;
        mmio_rd_valid = 1'b1; mmio_rd_addr = A_ADDR; mmio_rd_tid = 9'h033;
        @(negedge pClk);
        mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
        chk("rw_pre_value", mmio_rd_rsp_data, 64'h99);
        rchk("rw_post_value", A_ADDR, 64'h55);

        // Reset in the middle of WAIT
        mw(A_CMD, 64'h1);
        repeat (2) @(negedge pClk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_address", {32'd0, avm_address}, 64'd0);
        chk("arst_wdata", avm_writedata, 64'd0);
        chk("arst_burst", {52'd0, avm_burstcount}, 64'd1);
        chk("arst_strobes", {60'd0, avm_write, avm_read, mem_testmode, rdwr_reset}, 64'd0);
        @(negedge pClk);
        rst_n = 1'b1;
        cp0 = clr_pulses;
        repeat (5) @(negedge pClk);
        chk("arst_no_clear", 64'(clr_pulses - cp0), 64'd0);
        rchk("arst_status", A_STATUS, 64'h0);
        rchk("arst_lat", A_LAT, 64'h0);
        rchk("arst_burst_reg", A_BURST, 64'h1);
        rchk("arst_addr_reg", A_ADDR, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
